// File: rtl/prog3_pkg.sv
// Shared types and default addresses for the program-3 pattern count engine.
package prog3_pkg;

  localparam int unsigned PAT_W         = 5;
  localparam int unsigned DEF_STR_BYTES = 32;
  localparam int unsigned DEF_PAT_ADDR  = 32;
  localparam int unsigned DEF_RES_ADDR  = 33;
  localparam int unsigned DEF_AW        = 8;

  localparam int unsigned CTB_OFF = 0;
  localparam int unsigned CTO_OFF = 1;
  localparam int unsigned CTS_OFF = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SCAN = 3'd2,
    WR_B = 3'd3,
    WR_O = 3'd4,
    WR_S = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

// File: rtl/window_matcher.sv
// Counts 5-bit pattern hits in the current byte and across the {prev[3:0], cur} window.
module window_matcher
  import prog3_pkg::*;
(
  input  logic [11:0]      w_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic             first_i,
  output logic [2:0]       in_cnt_c,
  output logic             any_c,
  output logic [3:0]       cross_cnt_c
);

  always_comb begin
    in_cnt_c    = '0;
    cross_cnt_c = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_i[i +: PAT_W] == pat_i) in_cnt_c = in_cnt_c + 3'd1;
    end
    for (int i = 0; i < 8; i++) begin
      if (w_i[i +: PAT_W] == pat_i) cross_cnt_c = cross_cnt_c + 4'd1;
    end
    // The first byte has no predecessor, so only its own windows count.
    if (first_i) cross_cnt_c = {1'b0, in_cnt_c};
    any_c = (in_cnt_c != 3'd0);
  end

endmodule

// File: rtl/pattern_count_engine.sv
// Memory-port master that scans the message for a 5-bit pattern and writes three counts back.
module pattern_count_engine
  import prog3_pkg::*;
#(
  parameter int unsigned STR_BYTES = DEF_STR_BYTES,
  parameter int unsigned PAT_ADDR  = DEF_PAT_ADDR,
  parameter int unsigned RES_ADDR  = DEF_RES_ADDR,
  parameter int unsigned AW        = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wen,
  output logic [7:0]    mem_wdata
);

  localparam int unsigned IDX_W = (STR_BYTES > 1) ? $clog2(STR_BYTES) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       prev_q, prev_d;
  logic [7:0]       ctb_q, ctb_d;
  logic [7:0]       cto_q, cto_d;
  logic [7:0]       cts_q, cts_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             wen_q, wen_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             done_q, done_d;

  logic [2:0] in_cnt;
  logic       any_hit;
  logic [3:0] cross_cnt;

  window_matcher u_matcher (
    .w_i        ({prev_q, mem_rdata}),
    .pat_i      (pat_q),
    .first_i    (idx_q == '0),
    .in_cnt_c   (in_cnt),
    .any_c      (any_hit),
    .cross_cnt_c(cross_cnt)
  );

  // Next state plus the port values the next state will present (ports are registered).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    prev_d  = prev_q;
    ctb_d   = ctb_q;
    cto_d   = cto_q;
    cts_d   = cts_q;
    addr_d  = '0;
    wen_d   = 1'b0;
    wdata_d = '0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          ctb_d   = '0;
          cto_d   = '0;
          cts_d   = '0;
          addr_d  = AW'(PAT_ADDR);
        end
      end
      LOAD: begin
        pat_d   = mem_rdata[7:3];
        idx_d   = '0;
        state_d = SCAN;
        addr_d  = '0;
      end
      SCAN: begin
        ctb_d  = ctb_q + 8'(in_cnt);
        cto_d  = cto_q + 8'(any_hit);
        cts_d  = cts_q + 8'(cross_cnt);
        prev_d = mem_rdata[3:0];
        if (idx_q == IDX_W'(STR_BYTES - 1)) begin
          state_d = WR_B;
          addr_d  = AW'(RES_ADDR + CTB_OFF);
          wen_d   = 1'b1;
          wdata_d = ctb_d;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          addr_d = AW'(idx_d);
        end
      end
      WR_B: begin
        state_d = WR_O;
        addr_d  = AW'(RES_ADDR + CTO_OFF);
        wen_d   = 1'b1;
        wdata_d = cto_q;
      end
      WR_O: begin
        state_d = WR_S;
        addr_d  = AW'(RES_ADDR + CTS_OFF);
        wen_d   = 1'b1;
        wdata_d = cts_q;
      end
      WR_S: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
        if (start) begin
          state_d = LOAD;
          done_d  = 1'b0;
          ctb_d   = '0;
          cto_d   = '0;
          cts_d   = '0;
          addr_d  = AW'(PAT_ADDR);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      prev_q  <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      prev_q  <= prev_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_pattern_count_engine.sv
// Scoreboard bench: a bit-string reference model predicts the three result writes per run.
module tb_pattern_count_engine;

  localparam int RES_ADDR  = 33;
  localparam int PAT_ADDR  = 32;
  localparam int DONE_EDGE = 36;  // done visible 36 edges after the start edge (cycle E+37)

  logic       clk;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_wen;
  logic [7:0] mem_wdata;

  logic [7:0]  core [0:255];
  logic [15:0] exp_q [$];
  int total;
  int bad;

  pattern_count_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wen  (mem_wen),
    .mem_wdata(mem_wdata)
  );

  assign mem_rdata = core[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must be the next expected {addr,data}.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset && mem_wen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL result_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   mem_addr, mem_wdata, e[15:8], e[7:0]);
        end
      end
      core[mem_addr] = mem_wdata;
    end
  end

  // Treat the message as one 256-bit MSB-first string and slide a 5-bit window over it.
  task automatic ref_model(output logic [7:0] rb, output logic [7:0] ro, output logic [7:0] rs);
    bit   bits [256];
    bit   hit  [32];
    logic [4:0] p;
    logic [7:0] pb;
    int   b, o, s;
    logic m;
    pb = core[PAT_ADDR];
    p  = pb[7:3];
    for (int i = 0; i < 32; i++) begin
      hit[i] = 1'b0;
      for (int j = 0; j < 8; j++) bits[8*i + j] = core[i][7-j];
    end
    b = 0; o = 0; s = 0;
    for (int st = 0; st <= 251; st++) begin
      m = 1'b1;
      for (int t = 0; t < 5; t++) if (bits[st+t] != p[4-t]) m = 1'b0;
      if (m) begin
        s++;
        if ((st % 8) <= 3) begin
          b++;
          hit[st/8] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 32; i++) o += int'(hit[i]);
    rb = 8'(b); ro = 8'(o); rs = 8'(s);
  endtask

  task automatic run_case(input string nm);
    logic [7:0] e_b, e_o, e_s;
    int  k;
    bit  seen;
    ref_model(e_b, e_o, e_s);
    exp_q.push_back({8'(RES_ADDR),     e_b});
    exp_q.push_back({8'(RES_ADDR + 1), e_o});
    exp_q.push_back({8'(RES_ADDR + 2), e_s});
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check({nm, "_done_low_after_start"}, int'(done), 0);
    seen = 0; k = 0;
    while (!seen && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (done) seen = 1;
    end
    check({nm, "_done_latency"}, k, DONE_EDGE);
    @(negedge clk);
    check({nm, "_core_ctb"}, int'(core[RES_ADDR]),     int'(e_b));
    check({nm, "_core_cto"}, int'(core[RES_ADDR + 1]), int'(e_o));
    check({nm, "_core_cts"}, int'(core[RES_ADDR + 2]), int'(e_s));
    check({nm, "_writes_drained"}, exp_q.size(), 0);
  endtask

  task automatic fill(input logic [7:0] v, input logic [7:0] pat_byte);
    for (int i = 0; i < 32; i++) core[i] = v;
    core[PAT_ADDR] = pat_byte;
  endtask

  task automatic fill_random();
    logic [7:0] mask;
    mask = 8'($urandom);
    for (int i = 0; i < 32; i++) core[i] = 8'($urandom) & (($urandom_range(0, 1) == 1) ? mask : 8'hFF);
    if ($urandom_range(0, 1) == 1)
      core[PAT_ADDR] = {core[$urandom_range(0, 31)][4:0], 3'b000};
    else
      core[PAT_ADDR] = 8'($urandom);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) core[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done",  int'(done),      0);
    check("reset_wen",   int'(mem_wen),   0);
    check("reset_addr",  int'(mem_addr),  0);
    check("reset_wdata", int'(mem_wdata), 0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_done", int'(done), 0);

    fill(8'h00, 8'h00); run_case("zeros_pat0");
    fill(8'h00, 8'hF8); run_case("zeros_pat1f");
    fill(8'h55, 8'h50); run_case("alt55_pat0a");
    fill(8'h00, 8'hF8); core[0] = 8'h03; core[1] = 8'hE0; run_case("crossing_only");

    // Abort a run mid-scan: nothing may be written and done must stay low.
    fill_random();
    core[RES_ADDR] = 8'hEE; core[RES_ADDR+1] = 8'hEE; core[RES_ADDR+2] = 8'hEE;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (11) @(posedge clk);
    #1; reset = 1'b1;
    #1;
    check("midreset_done",  int'(done),      0);
    check("midreset_wen",   int'(mem_wen),   0);
    check("midreset_addr",  int'(mem_addr),  0);
    check("midreset_wdata", int'(mem_wdata), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    check("midreset_still_idle", int'(done), 0);
    check("midreset_no_ctb", int'(core[RES_ADDR]),     8'hEE);
    check("midreset_no_cto", int'(core[RES_ADDR + 1]), 8'hEE);
    check("midreset_no_cts", int'(core[RES_ADDR + 2]), 8'hEE);
    run_case("after_reset");

    // Back-to-back runs started straight from DONE with fresh data.
    for (int r = 0; r < 8; r++) begin
      fill_random();
      run_case($sformatf("rand%0d", r));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
